// File: rtl/cordic_multi_if.sv
// rtl/cordic_multi_if.sv - valid/ready sample and result bus for cordic_multi
interface cordic_multi_if #(
  parameter int WIDTH = 32
);
  // sample side
  logic             in_valid_i;
  logic             in_ready_o;
  logic             mode_i;
  logic [WIDTH-1:0] x_i;
  logic [WIDTH-1:0] y_i;
  logic [WIDTH-1:0] z_i;

  // result side
  logic             out_valid_o;
  logic             out_ready_i;
  logic             mode_o;
  logic [WIDTH-1:0] x_o;
  logic [WIDTH-1:0] y_o;
  logic [WIDTH-1:0] z_o;
  logic             sat_o;

  modport master (
    output in_valid_i, mode_i, x_i, y_i, z_i, out_ready_i,
    input  in_ready_o, out_valid_o, mode_o, x_o, y_o, z_o, sat_o
  );

  modport slave (
    input  in_valid_i, mode_i, x_i, y_i, z_i, out_ready_i,
    output in_ready_o, out_valid_o, mode_o, x_o, y_o, z_o, sat_o
  );
endinterface

// File: rtl/cordic_multi.sv
// rtl/cordic_multi.sv - pipelined vectoring/rotation CORDIC with gain compensation and backpressure
module cordic_multi #(
  parameter int Q_I    = 15,
  parameter int Q_F    = 16,
  parameter int WIDTH  = Q_I + Q_F + 1,
  parameter int STAGES = 16
) (
  input logic          clk_i,
  input logic          rst_i,
  cordic_multi_if.slave bus
);

  // two guard bits absorb the CORDIC growth (~1.65) plus the sqrt(2) of a full-scale vector
  localparam int IW = WIDTH + 2;
  // product width of a guarded sample times the Q_F-fraction gain constant
  localparam int PW = IW + Q_F + 2;

  localparam logic [WIDTH-1:0] HALF_TURN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] POS_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_MAX   = {1'b1, {(WIDTH-1){1'b0}}};

  generate
    if (WIDTH != Q_I + Q_F + 1 || WIDTH >= 64) begin : g_bad_width
      $error("cordic_multi: WIDTH must equal Q_I+Q_F+1 and be below 64");
    end
    if (STAGES < 4 || STAGES > WIDTH - 2) begin : g_bad_stages
      $error("cordic_multi: STAGES must lie in 4..WIDTH-2");
    end
  endgenerate

  // atan(2^-k) in binary-angle units, packed one WIDTH-bit entry per iteration
  function automatic logic [STAGES*WIDTH-1:0] atan_table();
    logic [STAGES*WIDTH-1:0] tab;
    real    pi;
    real    t;
    real    t2;
    real    term;
    real    sum;
    real    scale;
    real    val;
    longint q;
    tab   = '0;
    pi    = 3.14159265358979323846;
    scale = 1.0;
    for (int b = 0; b < WIDTH; b++) scale = scale * 2.0;
    t = 1.0;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        sum = pi / 4.0;
      end else begin
        // Maclaurin series; t <= 0.5 so 40 terms are far below one LSB
        t2   = t * t;
        term = t;
        sum  = 0.0;
        for (int n = 0; n < 40; n++) begin
          if (n % 2 == 0) sum = sum + term / (2.0 * $itor(n) + 1.0);
          else            sum = sum - term / (2.0 * $itor(n) + 1.0);
          term = term * t2;
        end
      end
      val = sum / (2.0 * pi) * scale;
      q   = longint'(val);
      tab[k*WIDTH +: WIDTH] = q[WIDTH-1:0];
      t = t / 2.0;
    end
    return tab;
  endfunction

  // 1/K for the configured iteration count, as an unsigned Q_F fraction
  function automatic logic signed [Q_F+1:0] gain_value();
    real    p;
    real    f;
    real    r;
    real    scale;
    longint q;
    p = 1.0;
    f = 1.0;
    for (int k = 0; k < STAGES; k++) begin
      p = p * (1.0 + f);
      f = f / 4.0;
    end
    // Newton iteration for 1/sqrt(p); p sits near 2.71 so 0.6 is a close start
    r = 0.6;
    for (int n = 0; n < 20; n++) r = r * (1.5 - 0.5 * p * r * r);
    scale = 1.0;
    for (int b = 0; b < Q_F; b++) scale = scale * 2.0;
    q = longint'(r * scale);
    return q[Q_F+1:0];
  endfunction

  localparam logic [STAGES*WIDTH-1:0] ATAN_TAB = atan_table();
  localparam logic signed [Q_F+1:0]   GAIN     = gain_value();
  localparam logic signed [PW-1:0]    GAIN_EXT = {{(PW-Q_F-2){1'b0}}, GAIN};

  // stage 0 is the pre-rotation result, stage k+1 the result of iteration k
  logic                 vld [0:STAGES];
  logic                 md  [0:STAGES];
  logic signed [IW-1:0] xr  [0:STAGES];
  logic signed [IW-1:0] yr  [0:STAGES];
  logic [WIDTH-1:0]     zr  [0:STAGES];

  logic signed [IW-1:0] nx [0:STAGES-1];
  logic signed [IW-1:0] ny [0:STAGES-1];
  logic [WIDTH-1:0]     nz [0:STAGES-1];

  logic                 advance;
  logic signed [IW-1:0] x_ext;
  logic signed [IW-1:0] y_ext;
  logic signed [IW-1:0] pre_x;
  logic signed [IW-1:0] pre_y;
  logic [WIDTH-1:0]     pre_z;

  logic signed [PW-1:0] px;
  logic signed [PW-1:0] py;
  logic signed [PW-1:0] sx;
  logic signed [PW-1:0] sy;
  logic                 clip_x;
  logic                 clip_y;
  logic [WIDTH-1:0]     gx;
  logic [WIDTH-1:0]     gy;

  // the whole pipe moves as one; a held result freezes every stage behind it
  assign advance        = !bus.out_valid_o || bus.out_ready_i;
  assign bus.in_ready_o = advance;

  // fold the input into the right half-plane so the iterations only need +-90 degrees of reach
  always_comb begin
    x_ext = {{2{bus.x_i[WIDTH-1]}}, bus.x_i};
    y_ext = {{2{bus.y_i[WIDTH-1]}}, bus.y_i};
    pre_x = x_ext;
    pre_y = y_ext;
    pre_z = '0;
    if (bus.mode_i) begin
      pre_y = '0;
      pre_z = bus.z_i;
      if (bus.z_i[WIDTH-1] != bus.z_i[WIDTH-2]) begin
        pre_x = -x_ext;
        pre_z = bus.z_i - HALF_TURN;
      end
    end else if (x_ext[IW-1]) begin
      pre_x = -x_ext;
      pre_y = -y_ext;
      pre_z = HALF_TURN;
    end
  end

  // micro-rotations: counter-clockwise when vectoring below the axis or rotating toward a positive angle
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      if (md[k] ? !zr[k][WIDTH-1] : yr[k][IW-1]) begin
        nx[k] = xr[k] - (yr[k] >>> k);
        ny[k] = yr[k] + (xr[k] >>> k);
        nz[k] = zr[k] - ATAN_TAB[k*WIDTH +: WIDTH];
      end else begin
        nx[k] = xr[k] + (yr[k] >>> k);
        ny[k] = yr[k] - (xr[k] >>> k);
        nz[k] = zr[k] + ATAN_TAB[k*WIDTH +: WIDTH];
      end
    end
  end

  // remove the CORDIC gain and clip anything that no longer fits the signed output width
  always_comb begin
    px     = {{(PW-IW){xr[STAGES][IW-1]}}, xr[STAGES]} * GAIN_EXT;
    py     = {{(PW-IW){yr[STAGES][IW-1]}}, yr[STAGES]} * GAIN_EXT;
    sx     = px >>> Q_F;
    sy     = py >>> Q_F;
    clip_x = !((&sx[PW-1:WIDTH-1]) || !(|sx[PW-1:WIDTH-1]));
    clip_y = !((&sy[PW-1:WIDTH-1]) || !(|sy[PW-1:WIDTH-1]));
    gx     = sx[WIDTH-1:0];
    gy     = sy[WIDTH-1:0];
    if (clip_x) gx = sx[PW-1] ? NEG_MAX : POS_MAX;
    if (clip_y) gy = sy[PW-1] ? NEG_MAX : POS_MAX;
  end

  // pipeline and output registers; reset flushes everything in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k <= STAGES; k++) begin
        vld[k] <= 1'b0;
        md[k]  <= 1'b0;
        xr[k]  <= '0;
        yr[k]  <= '0;
        zr[k]  <= '0;
      end
      bus.out_valid_o <= 1'b0;
      bus.mode_o      <= 1'b0;
      bus.x_o         <= '0;
      bus.y_o         <= '0;
      bus.z_o         <= '0;
      bus.sat_o       <= 1'b0;
    end else if (advance) begin
      vld[0] <= bus.in_valid_i;
      md[0]  <= bus.mode_i;
      xr[0]  <= pre_x;
      yr[0]  <= pre_y;
      zr[0]  <= pre_z;
      for (int k = 0; k < STAGES; k++) begin
        vld[k+1] <= vld[k];
        md[k+1]  <= md[k];
        xr[k+1]  <= nx[k];
        yr[k+1]  <= ny[k];
        zr[k+1]  <= nz[k];
      end
      bus.out_valid_o <= vld[STAGES];
      bus.mode_o      <= md[STAGES];
      bus.x_o         <= gx;
      bus.y_o         <= gy;
      bus.z_o         <= zr[STAGES];
      bus.sat_o       <= clip_x || clip_y;
    end
  end

endmodule
